// File: rtl/int_ctrl_pkg.sv
// Shared constants and helpers for the external interrupt controller.
// Holds the register offsets, the ID width and the lowest-ID priority encoder.
package int_ctrl_pkg;

    localparam logic [7:0] INT_CTRL_PENDING_ADDR   = 8'h00;
    localparam logic [7:0] INT_CTRL_ENABLE_ADDR    = 8'h04;
    localparam logic [7:0] INT_CTRL_CLAIM_ADDR     = 8'h08;
    localparam logic [7:0] INT_CTRL_INSERVICE_ADDR = 8'h0C;

    localparam int         INT_CTRL_ID_WIDTH  = 5;
    localparam logic [1:0] INT_CTRL_SIZE_WORD = 2'b10;

    // Returns the 1-based ID of the lowest set bit, or 0 when the vector is empty.
    function automatic logic [INT_CTRL_ID_WIDTH-1:0] lowest_id(input logic [30:0] vec);
        logic [INT_CTRL_ID_WIDTH-1:0] id;
        id = '0;
        for (int i = 30; i >= 0; i--) begin
            if (vec[i]) begin
                id = INT_CTRL_ID_WIDTH'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/int_source_gateway.sv
// Per-source front end: optional two-flop synchronizer (INT_CTRL_SYNC_EN)
// followed by a rising-edge detector producing a one-cycle pulse.
module int_source_gateway (
    input  logic clk,
    input  logic reset_n,
    input  logic src,
    output logic edge_pulse
);

    logic src_s;
    logic src_prev;

`ifdef INT_CTRL_SYNC_EN
    logic sync_1;
    logic sync_2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= src;
            sync_2 <= sync_1;
        end
    end

    assign src_s = sync_2;
`else
    assign src_s = src;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_prev <= 1'b0;
        end else begin
            src_prev <= src_s;
        end
    end

    assign edge_pulse = src_s & ~src_prev;

endmodule

// File: rtl/int_controller.sv
// Memory-mapped external interrupt controller with claim/complete handshake.
// Build option INT_CTRL_SYNC_EN adds a two-flop synchronizer on every source.
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SOURCES = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SOURCES-1:0] src_irq,
    input  logic                   bus_req,
    input  logic                   bus_write,
    input  logic [1:0]             bus_size,
    input  logic [7:0]             bus_addr,
    input  logic [31:0]            bus_wdata,
    output logic [31:0]            bus_rdata,
    output logic                   bus_ack,
    output logic                   bus_fault,
    output logic                   ext_int
);

    logic [NUM_SOURCES-1:0]       pending;
    logic [NUM_SOURCES-1:0]       enable;
    logic [NUM_SOURCES-1:0]       edge_pulse;
    logic [NUM_SOURCES-1:0]       active;
    logic [NUM_SOURCES-1:0]       claim_mask;
    logic [INT_CTRL_ID_WIDTH-1:0] inservice;
    logic [INT_CTRL_ID_WIDTH-1:0] claim_id;
    logic                         access_bad;
    logic                         access_ok;
    logic                         do_claim;
    logic                         do_complete;
    logic                         do_enable_wr;
    logic [31:0]                  rdata_next;
    logic                         unused_wdata;

    assign unused_wdata = ^bus_wdata;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
        int_source_gateway u_gateway (
            .clk        (clk),
            .reset_n    (reset_n),
            .src        (src_irq[g]),
            .edge_pulse (edge_pulse[g])
        );
    end

    always_comb begin
        active     = pending & enable;
        claim_id   = lowest_id(31'(active));
        access_bad = (bus_size != INT_CTRL_SIZE_WORD) || (bus_addr[1:0] != 2'b00) ||
                     (bus_addr > INT_CTRL_INSERVICE_ADDR) ||
                     (bus_write && (bus_addr == INT_CTRL_PENDING_ADDR ||
                                    bus_addr == INT_CTRL_INSERVICE_ADDR));
        access_ok    = bus_req && !access_bad;
        do_enable_wr = access_ok && bus_write && (bus_addr == INT_CTRL_ENABLE_ADDR);
        do_complete  = access_ok && bus_write && (bus_addr == INT_CTRL_CLAIM_ADDR) &&
                       (bus_wdata[INT_CTRL_ID_WIDTH-1:0] == inservice);
        do_claim     = access_ok && !bus_write && (bus_addr == INT_CTRL_CLAIM_ADDR) &&
                       (inservice == '0) && (|active);
        // Isolate the lowest active bit; it matches claim_id.
        claim_mask   = do_claim ? (active & (~active + NUM_SOURCES'(1))) : '0;

        rdata_next = '0;
        if (access_ok && !bus_write) begin
            case (bus_addr)
                INT_CTRL_PENDING_ADDR:   rdata_next = 32'(pending);
                INT_CTRL_ENABLE_ADDR:    rdata_next = 32'(enable);
                INT_CTRL_CLAIM_ADDR:     rdata_next = do_claim ? 32'(claim_id) : '0;
                INT_CTRL_INSERVICE_ADDR: rdata_next = 32'(inservice);
                default:                 rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            enable    <= '0;
            inservice <= '0;
            bus_ack   <= 1'b0;
            bus_fault <= 1'b0;
            bus_rdata <= '0;
            ext_int   <= 1'b0;
        end else begin
            // A new edge on the claimed source re-arms its flag instead of being lost.
            pending <= (pending & ~claim_mask) | edge_pulse;
            if (do_enable_wr) begin
                enable <= bus_wdata[NUM_SOURCES-1:0];
            end
            if (do_claim) begin
                inservice <= claim_id;
            end else if (do_complete) begin
                inservice <= '0;
            end
            bus_ack   <= bus_req;
            bus_fault <= bus_req && access_bad;
            bus_rdata <= rdata_next;
            ext_int   <= (|active) && (inservice == '0);
        end
    end

endmodule

// File: doc/int_controller.md
# int_controller

Memory-mapped external interrupt controller that drives the core's single `ext_int` input. It latches rising edges on up to 31 interrupt source lines, masks them with an enable register and presents the lowest-numbered enabled pending source through a claim/complete register pair. It sits on the core's data bus as a word-only responder and allows one interrupt in service at a time.

## Interface
- `NUM_SOURCES`, default 8: number of source lines; legal range 1..31; source IDs are 1..NUM_SOURCES, and ID 0 means "none".
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `src_irq` input NUM_SOURCES: interrupt lines; bit i is source ID i+1; rising-edge sensitive.
- `bus_req` input 1: access request, valid for one cycle.
- `bus_write` input 1: 1 for a write, 0 for a read; qualified by `bus_req`.
- `bus_size` input 2: access size; only 2'b10 (word) is legal.
- `bus_addr` input 8: byte offset within the block.
- `bus_wdata` input 32: write data.
- `bus_rdata` output 32: read data; valid while `bus_ack` is high, 0 otherwise.
- `bus_ack` output 1: response strobe, one cycle wide.
- `bus_fault` output 1: the access was rejected; it is valid with `bus_ack`.
- `ext_int` output 1: interrupt request to the core; registered.

## Operation
- Registers, all word-aligned:
  - 0x00 PENDING (RO): bit i is the pending flag of source i+1.
  - 0x04 ENABLE (RW): bit i enables source i+1.
  - 0x08 CLAIM (RW): claim/complete register, described below.
  - 0x0C INSERVICE (RO): ID of the claimed source, or 0.
  - Bits at or above NUM_SOURCES read 0 and ignore writes.
- Pending set: a rising edge on a source sets its pending flag. The flag stays set regardless of ENABLE until the source is claimed.
- CLAIM read when INSERVICE==0 and some source is enabled and pending:
  - Returns the lowest such ID.
  - Clears that pending flag and loads INSERVICE with that ID.
- CLAIM read when INSERVICE!=0 or nothing is enabled and pending: returns 0 with no state change.
- CLAIM write:
  - If `bus_wdata[4:0]` equals INSERVICE, INSERVICE clears to 0.
  - Any other value is ignored and does not fault.
- `ext_int` next value is (|(PENDING & ENABLE)) & (INSERVICE==0).
- Faults (response has `bus_ack`=1, `bus_fault`=1, `bus_rdata`=0, and no state change):
  - `bus_size`!=2'b10;
  - `bus_addr[1:0]`!=0;
  - `bus_addr`>0x0C;
  - a write to PENDING or INSERVICE.
- Simultaneous events:
  - An edge on source s in the same cycle that s is claimed: the claim takes INSERVICE=s and the pending flag remains set, so the new edge is not lost.
  - An edge arriving while the source is already pending merges into the existing flag.
  - A complete and a new edge in the same cycle: both take effect, and `ext_int` rises on the following cycle.
- Reset: PENDING, ENABLE and INSERVICE clear to 0 and the edge-detect history clears. A request in flight when reset asserts is dropped and gets no ack.

## Timing
- Reset values: `bus_rdata`=0, `bus_ack`=0, `bus_fault`=0, `ext_int`=0.
- Bus:
  - A request sampled at edge k produces `bus_ack`, `bus_fault` and `bus_rdata` during the cycle after edge k, i.e. one cycle of latency.
  - Back-to-back requests are accepted every cycle.
  - Register side effects (claim, complete, ENABLE write) are committed at edge k.
- Source to pending, without synchronizer: `src_irq` is first sampled high at edge k; pending is set at edge k and `ext_int` is high after edge k+1.
- Source to pending, with synchronizer: pending is set at edge k+2 and `ext_int` is high after edge k+3.
- Claim to `ext_int`: a claim at edge k drives `ext_int` low after edge k+1.
- Sources must stay low for at least one sampled cycle between edges; narrower gaps may merge.

## Configuration
- `INT_CTRL_SYNC_EN`, defined: each source passes through a two-flop synchronizer, reset to 0, before edge detection. Sources may be asynchronous to `clk`.
- Not defined: sources feed edge detection directly and must be synchronous to `clk`. Latency is two cycles shorter, as given in Timing.

## Structure
- Package `int_ctrl_pkg` holds:
  - the offset constants `INT_CTRL_PENDING_ADDR`, `INT_CTRL_ENABLE_ADDR`, `INT_CTRL_CLAIM_ADDR` and `INT_CTRL_INSERVICE_ADDR`;
  - `INT_CTRL_ID_WIDTH`=5;
  - the word-size constant 2'b10 shared with the memory module.
- Sub-module `int_source_gateway`, instantiated once per source with a generate loop, contains the optional synchronizer, the previous-value flop and a one-cycle rising-edge pulse output.
- The priority encoder (lowest ID wins) is a function in the package.

## Test plan
- Reset, then read all four registers: all return 0, `bus_fault`=0, `ext_int`=0.
- ENABLE=0x05, then pulse sources 3 and 1 in the same cycle: PENDING=0x05 and `ext_int`=1.
  - First CLAIM read returns 1 and INSERVICE=1.
  - A second CLAIM read returns 0.
  - Writing CLAIM=1 makes `ext_int` return to 1, and the next CLAIM read returns 3.
- Pulse source 2 with ENABLE=0: PENDING=0x02 and `ext_int` stays 0. Setting ENABLE=0x02 raises `ext_int` one cycle after the write's edge.
- Write CLAIM=4 while INSERVICE=1: no fault and INSERVICE stays 1.
- Each of the following returns `bus_ack`=1, `bus_fault`=1 with no state change:
  - byte read at 0x04;
  - word read at 0x06;
  - word read at 0x10;
  - write to 0x00.
- Edge on source 1 in the same cycle as its claim: INSERVICE=1 and PENDING bit 0 still 1. After completion, `ext_int` reasserts.
- Assert `reset_n` low mid-request: no ack, all registers 0.
